// File: rtl/cpu_mem_initiator.sv
// CPU-port initiator: takes one host command at a time, holds a level request to the
// memory controller until its ack pulse, and returns the response or a timeout error.
module cpu_mem_initiator #(
  parameter int ADDR_WIDTH = 8,
  parameter int DATA_WIDTH = 16,
  parameter int TIMEOUT    = 255,
  parameter int TO_WIDTH   = 8
) (
  input  logic                  clockCore,
  input  logic                  resetCore,
  input  logic                  cmdValid,
  output logic                  cmdReady,
  input  logic                  cmdRd,
  input  logic [ADDR_WIDTH-1:0] cmdAddr,
  input  logic [DATA_WIDTH-1:0] cmdWrData,
  output logic                  rspValid,
  input  logic                  rspReady,
  output logic                  rspErr,
  output logic [DATA_WIDTH-1:0] rspRdData,
  output logic                  cpuMemReq,
  output logic                  cpuMemRd,
  output logic [ADDR_WIDTH-1:0] cpuMemAddr,
  output logic [DATA_WIDTH-1:0] cpuMemWrData,
  input  logic                  cpuMemAck,
  input  logic [DATA_WIDTH-1:0] cpuMemRdData,
  output logic                  staleAck
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    REQ  = 2'd1,
    RSP  = 2'd2
  } state_t;

  // The counter holds (REQ edges seen - 1), so the timeout fires on the edge where it
  // equals TIMEOUT-1: exactly TIMEOUT edges after the request rose.
  localparam logic [TO_WIDTH-1:0] TimeoutLast = TO_WIDTH'(TIMEOUT - 1);
  localparam logic [TO_WIDTH-1:0] TimeoutMax  = TO_WIDTH'(TIMEOUT);
  localparam logic [TO_WIDTH-1:0] CountOne    = TO_WIDTH'(1);

  state_t                state_q, state_d;
  logic [TO_WIDTH-1:0]   count_q, count_d;
  logic                  req_q, req_d;
  logic                  rd_q, rd_d;
  logic [ADDR_WIDTH-1:0] addr_q, addr_d;
  logic [DATA_WIDTH-1:0] wrData_q, wrData_d;
  logic                  rspValid_q, rspValid_d;
  logic                  rspErr_q, rspErr_d;
  logic [DATA_WIDTH-1:0] rspRdData_q, rspRdData_d;
  logic                  staleAck_q, staleAck_d;

  always_ff @(posedge clockCore or negedge resetCore) begin
    if (!resetCore) begin
      state_q     <= IDLE;
      count_q     <= '0;
      req_q       <= 1'b0;
      rd_q        <= 1'b0;
      addr_q      <= '0;
      wrData_q    <= '0;
      rspValid_q  <= 1'b0;
      rspErr_q    <= 1'b0;
      rspRdData_q <= '0;
      staleAck_q  <= 1'b0;
    end else begin
      state_q     <= state_d;
      count_q     <= count_d;
      req_q       <= req_d;
      rd_q        <= rd_d;
      addr_q      <= addr_d;
      wrData_q    <= wrData_d;
      rspValid_q  <= rspValid_d;
      rspErr_q    <= rspErr_d;
      rspRdData_q <= rspRdData_d;
      staleAck_q  <= staleAck_d;
    end
  end

  always_comb begin
    state_d     = state_q;
    count_d     = count_q;
    req_d       = req_q;
    rd_d        = rd_q;
    addr_d      = addr_q;
    wrData_d    = wrData_q;
    rspValid_d  = rspValid_q;
    rspErr_d    = rspErr_q;
    rspRdData_d = rspRdData_q;
    staleAck_d  = 1'b0;
    case (state_q)
      IDLE: begin
        staleAck_d = cpuMemAck;
        if (cmdValid) begin
          rd_d     = cmdRd;
          addr_d   = cmdAddr;
          wrData_d = cmdWrData;
          req_d    = 1'b1;
          count_d  = '0;
          state_d  = REQ;
        end
      end
      REQ: begin
        count_d = (count_q == TimeoutMax) ? count_q : count_q + CountOne;
        // Ack takes priority over a timeout landing on the same edge.
        if (cpuMemAck) begin
          req_d       = 1'b0;
          rspRdData_d = rd_q ? cpuMemRdData : '0;
          rspErr_d    = 1'b0;
          rspValid_d  = 1'b1;
          state_d     = RSP;
        end else if (count_q == TimeoutLast) begin
          req_d       = 1'b0;
          rspRdData_d = '0;
          rspErr_d    = 1'b1;
          rspValid_d  = 1'b1;
          state_d     = RSP;
        end
      end
      RSP: begin
        staleAck_d = cpuMemAck;
        if (rspReady) begin
          rspValid_d = 1'b0;
          rspErr_d   = 1'b0;
          state_d    = IDLE;
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  assign cmdReady     = (state_q == IDLE);
  assign cpuMemReq    = req_q;
  assign cpuMemRd     = rd_q;
  assign cpuMemAddr   = addr_q;
  assign cpuMemWrData = wrData_q;
  assign rspValid     = rspValid_q;
  assign rspErr       = rspErr_q;
  assign rspRdData    = rspRdData_q;
  assign staleAck     = staleAck_q;

endmodule

// File: tb/tb_cpu_mem_initiator.sv
// Directed plus randomized bench for cpu_mem_initiator, using a word-array memory model
// and response timing derived from ack latency versus the timeout limit.
module tb_cpu_mem_initiator;

  localparam int AW = 8;
  localparam int DW = 16;
  localparam int TO = 16;

  logic          clockCore = 1'b0;
  logic          resetCore = 1'b0;
  logic          cmdValid = 1'b0;
  logic          cmdReady;
  logic          cmdRd = 1'b0;
  logic [AW-1:0] cmdAddr = '0;
  logic [DW-1:0] cmdWrData = '0;
  logic          rspValid;
  logic          rspReady = 1'b1;
  logic          rspErr;
  logic [DW-1:0] rspRdData;
  logic          cpuMemReq;
  logic          cpuMemRd;
  logic [AW-1:0] cpuMemAddr;
  logic [DW-1:0] cpuMemWrData;
  logic          cpuMemAck = 1'b0;
  logic [DW-1:0] cpuMemRdData = '0;
  logic          staleAck;

  int vectors = 0;
  int miscompares = 0;
  logic [DW-1:0] mem [256];
  logic          lastErr;
  logic [DW-1:0] lastData;

  cpu_mem_initiator #(
    .ADDR_WIDTH(AW), .DATA_WIDTH(DW), .TIMEOUT(TO), .TO_WIDTH(8)
  ) dut (
    .clockCore(clockCore), .resetCore(resetCore),
    .cmdValid(cmdValid), .cmdReady(cmdReady), .cmdRd(cmdRd),
    .cmdAddr(cmdAddr), .cmdWrData(cmdWrData),
    .rspValid(rspValid), .rspReady(rspReady), .rspErr(rspErr), .rspRdData(rspRdData),
    .cpuMemReq(cpuMemReq), .cpuMemRd(cpuMemRd), .cpuMemAddr(cpuMemAddr),
    .cpuMemWrData(cpuMemWrData), .cpuMemAck(cpuMemAck), .cpuMemRdData(cpuMemRdData),
    .staleAck(staleAck)
  );

  always #5 clockCore = ~clockCore;

  initial begin
    #2000000;
    $display("[TB] FAIL watchdog observed=expired expected=finished");
    $fatal(1, "[TB] watchdog");
  end

  task automatic checkOutput(input string tag, input logic [63:0] observed,
                             input logic [63:0] expected);
    vectors++;
    assert (observed === expected)
    else begin
      miscompares++;
      $error("[TB] FAIL %s observed=0x%0h expected=0x%0h", tag, observed, expected);
    end
  endtask

  task automatic tick();
    @(posedge clockCore);
    #1;
  endtask

  // Present one command while the initiator is idle; it is accepted on the next edge.
  task automatic applyStimulus(input logic rd, input logic [AW-1:0] addr,
                               input logic [DW-1:0] wdata);
    checkOutput("cmdReadyBefore", 64'(cmdReady), 64'(1));
    cmdValid  = 1'b1;
    cmdRd     = rd;
    cmdAddr   = addr;
    cmdWrData = wdata;
    tick();
    cmdValid  = 1'b0;
    cmdAddr   = 8'($urandom);
    cmdWrData = 16'($urandom);
    checkOutput("accept", 64'({cpuMemReq, cpuMemRd, cpuMemAddr, cpuMemWrData, cmdReady}),
                64'({1'b1, rd, addr, wdata, 1'b0}));
  endtask

  // Controller model: ack after ackLat edges (0 = never); response due at min(ackLat, TO).
  task automatic awaitResponse(input int ackLat, input logic rd, input logic [AW-1:0] addr,
                               input logic [DW-1:0] wdata);
    int respAt;
    logic acked;
    logic [DW-1:0] expData;
    acked   = (ackLat >= 1) && (ackLat <= TO);
    respAt  = acked ? ackLat : TO;
    expData = (acked && rd) ? mem[addr] : 16'h0000;
    for (int k = 1; k <= respAt; k++) begin
      if (k == ackLat) begin
        cpuMemAck    = 1'b1;
        cpuMemRdData = rd ? mem[addr] : 16'($urandom);
      end
      tick();
      cpuMemAck    = 1'b0;
      cpuMemRdData = 16'($urandom);
      if (k < respAt)
        checkOutput("reqHold", 64'({cpuMemReq, cpuMemRd, cpuMemAddr, cpuMemWrData, rspValid, cmdReady}),
                    64'({1'b1, rd, addr, wdata, 1'b0, 1'b0}));
    end
    checkOutput("response", 64'({cpuMemReq, rspValid, rspErr, rspRdData}),
                64'({1'b0, 1'b1, !acked, expData}));
    if (acked && !rd) mem[addr] = wdata;
    lastErr  = !acked;
    lastData = expData;
  endtask

  // Hold rspReady low for holdCycles, then accept the response.
  task automatic releaseResponse(input int holdCycles);
    rspReady = 1'b0;
    for (int i = 0; i < holdCycles; i++) begin
      tick();
      checkOutput("rspHeld", 64'({rspValid, rspErr, rspRdData, cmdReady, cpuMemReq}),
                  64'({1'b1, lastErr, lastData, 1'b0, 1'b0}));
    end
    rspReady = 1'b1;
    tick();
    checkOutput("rspDone", 64'({rspValid, rspErr, cmdReady, cpuMemReq}),
                64'({1'b0, 1'b0, 1'b1, 1'b0}));
  endtask

  task automatic checkResetValues(input string tag);
    checkOutput(tag, 64'({cmdReady, cpuMemReq, cpuMemRd, cpuMemAddr, cpuMemWrData,
                          rspValid, rspErr, rspRdData, staleAck}),
                64'({1'b1, 1'b0, 1'b0, 8'h00, 16'h0000, 1'b0, 1'b0, 16'h0000, 1'b0}));
  endtask

  initial begin
    logic rd;
    logic [AW-1:0] addr;
    logic [DW-1:0] data;
    int lat;
    for (int i = 0; i < 256; i++) mem[i] = 16'($urandom);
    mem[8'h34] = 16'hA5A5;

    #2;
    checkResetValues("resetValues");
    #20;
    resetCore = 1'b1;
    tick();
    checkResetValues("afterRelease");

    applyStimulus(1'b0, 8'h12, 16'hBEEF);
    awaitResponse(4, 1'b0, 8'h12, 16'hBEEF);
    releaseResponse(0);

    applyStimulus(1'b1, 8'h34, 16'h1111);
    awaitResponse(4, 1'b1, 8'h34, 16'h1111);
    releaseResponse(0);

    // Back-to-back read/write/read; req stays low through RSP and IDLE in between.
    applyStimulus(1'b1, 8'h12, 16'h0000);
    awaitResponse(4, 1'b1, 8'h12, 16'h0000);
    releaseResponse(0);
    applyStimulus(1'b0, 8'h56, 16'h1234);
    awaitResponse(4, 1'b0, 8'h56, 16'h1234);
    releaseResponse(0);
    applyStimulus(1'b1, 8'h56, 16'h0000);
    awaitResponse(4, 1'b1, 8'h56, 16'h0000);
    releaseResponse(0);

    // Timeout, then a late ack seen as stale while the error response is held.
    rspReady = 1'b0;
    applyStimulus(1'b1, 8'h34, 16'h0000);
    awaitResponse(0, 1'b1, 8'h34, 16'h0000);
    tick();
    tick();
    cpuMemAck = 1'b1;
    tick();
    cpuMemAck = 1'b0;
    checkOutput("staleAfterTimeout", 64'({staleAck, rspValid, rspErr, rspRdData, cmdReady}),
                64'({1'b1, 1'b1, 1'b1, 16'h0000, 1'b0}));
    tick();
    checkOutput("stalePulseEnds", 64'({staleAck, rspValid, rspErr}), 64'({1'b0, 1'b1, 1'b1}));
    releaseResponse(0);

    // Ack on the very edge the timeout would fire: ack wins.
    applyStimulus(1'b1, 8'h34, 16'h0000);
    awaitResponse(TO, 1'b1, 8'h34, 16'h0000);
    releaseResponse(0);

    // Response held 10 cycles with a competing command pending.
    rspReady = 1'b0;
    applyStimulus(1'b1, 8'h34, 16'h0000);
    awaitResponse(3, 1'b1, 8'h34, 16'h0000);
    cmdValid  = 1'b1;
    cmdRd     = 1'b1;
    cmdAddr   = 8'h77;
    cmdWrData = 16'h0000;
    for (int i = 0; i < 10; i++) begin
      tick();
      checkOutput("heldNoAccept", 64'({rspValid, rspRdData, cmdReady, cpuMemReq}),
                  64'({1'b1, 16'hA5A5, 1'b0, 1'b0}));
    end
    rspReady = 1'b1;
    tick();
    checkOutput("idleAfterReady", 64'({rspValid, cmdReady, cpuMemReq}), 64'({1'b0, 1'b1, 1'b0}));
    tick();
    cmdValid = 1'b0;
    checkOutput("acceptAfterReady", 64'({cpuMemReq, cpuMemRd, cpuMemAddr, cmdReady}),
                64'({1'b1, 1'b1, 8'h77, 1'b0}));
    awaitResponse(4, 1'b1, 8'h77, 16'h0000);
    releaseResponse(0);

    // Randomized accesses against the memory model.
    for (int n = 0; n < 40; n++) begin
      rd   = 1'($urandom);
      addr = 8'($urandom);
      data = 16'($urandom);
      lat  = ($urandom_range(0, 7) == 0) ? 0 : int'($urandom_range(1, 8));
      applyStimulus(rd, addr, data);
      awaitResponse(lat, rd, addr, data);
      releaseResponse(int'($urandom_range(0, 3)));
    end

    // Reset two cycles into REQ abandons the access; a later ack is stale.
    applyStimulus(1'b0, 8'h99, 16'hCAFE);
    tick();
    tick();
    #2;
    resetCore = 1'b0;
    #1;
    checkResetValues("asyncReset");
    @(posedge clockCore);
    #3;
    resetCore = 1'b1;
    tick();
    checkResetValues("postResetIdle");
    cpuMemAck = 1'b1;
    tick();
    cpuMemAck = 1'b0;
    checkOutput("staleAfterReset", 64'({staleAck, cmdReady, cpuMemReq, rspValid}),
                64'({1'b1, 1'b1, 1'b0, 1'b0}));
    tick();
    checkOutput("staleAfterResetEnds", 64'(staleAck), 64'(0));

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/cpu_mem_initiator.md
# cpu_mem_initiator

CPU-side initiator for the generic dual-port memory controller's low-priority CPU port. It accepts single read/write commands from the host register decoder over a valid/ready handshake and drives the level-held cpuMemReq/cpuMemRd/cpuMemAddr/cpuMemWrData request. It waits for the one-cycle cpuMemAck, captures read data, and returns a response with a timeout error path. One access is in flight at a time, and it sits between the host slave decoder and each memory controller instance.

## Interface
- ADDR_WIDTH, 8, memory word address width
- DATA_WIDTH, 16, data width
- TIMEOUT, 255, max cycles in REQ without ack before error (≥8)
- TO_WIDTH, 8, timeout counter width (2^TO_WIDTH > TIMEOUT)

- clockCore  in  1  core clock
- resetCore  in  1  asynchronous, active-low reset
- cmdValid  in  1  host command valid
- cmdReady  out  1  initiator can accept command
- cmdRd  in  1  1=read, 0=write
- cmdAddr  in  ADDR_WIDTH  command address
- cmdWrData  in  DATA_WIDTH  write data
- rspValid  out  1  response valid, held until rspReady
- rspReady  in  1  host accepts response
- rspErr  out  1  access timed out
- rspRdData  out  DATA_WIDTH  read data (0 for writes and errors)
- cpuMemReq  out  1  request level to controller
- cpuMemRd  out  1  request type
- cpuMemAddr  out  ADDR_WIDTH  request address
- cpuMemWrData  out  DATA_WIDTH  request write data
- cpuMemAck  in  1  one-cycle completion pulse
- cpuMemRdData  in  DATA_WIDTH  read data, valid in the ack cycle
- staleAck  out  1  one-cycle pulse: ack received outside REQ

## Operation
- States: IDLE, REQ, RSP. All outputs are registered except cmdReady, which equals (state==IDLE).
- IDLE: on cmdValid&cmdReady, latch cmdRd/cmdAddr/cmdWrData into cpuMemRd/cpuMemAddr/cpuMemWrData, set cpuMemReq=1, clear the counter, and go to REQ.
- REQ: cpuMemReq, cpuMemRd, cpuMemAddr and cpuMemWrData are held constant. The controller edge-detects req, samples addr late and uses wrData combinationally, so these must not change until ack.
  - Counter increments each REQ cycle and saturates at TIMEOUT.
- Ack sampled in REQ:
  - cpuMemReq←0.
  - rspRdData←cpuMemRd ? cpuMemRdData : 0.
  - rspErr←0, rspValid←1.
  - Go to RSP.
- Counter==TIMEOUT with no ack at that edge:
  - cpuMemReq←0, rspErr←1, rspRdData←0, rspValid←1.
  - Go to RSP.
- Ack and counter==TIMEOUT at the same edge: ack wins and the response is normal.
- RSP: on rspReady, rspValid←0, rspErr←0, go to IDLE. The RSP and IDLE cycles guarantee that cpuMemReq is low for ≥2 cycles between accesses, so the controller detects a fresh rising edge each time.
- Ack sampled in IDLE or RSP: staleAck←1 for one cycle, data discarded, no state change.
- Reset values:
  - state=IDLE
  - cpuMemReq=0, cpuMemRd=0, cpuMemAddr=0, cpuMemWrData=0
  - rspValid=0, rspErr=0, rspRdData=0
  - staleAck=0, counter=0
  - cmdReady=1 after reset release
- Reset mid-REQ: req drops immediately and the in-flight access is abandoned. A later ack is ignored as stale only if it arrives after reset release.

## Timing
- Command accept edge E0: cpuMemReq=1 visible from E0.
- Ack sampled at edge Ea: rspValid=1 from Ea, cpuMemReq=0 from Ea.
- With an uncontended controller, ack returns 4 cycles after req rises, so cmd-accept→rspValid = 4 cycles.
- rspReady already high: RSP lasts 1 cycle, IDLE 1 cycle. Back-to-back command throughput is one per (ack latency + 2) cycles.
- Timeout: if cpuMemReq rises at E0 and no ack arrives, rspValid rises at edge E0+TIMEOUT.
- cmdReady=0 throughout REQ and RSP. cmdValid is ignored there.

## Test plan
- Write addr 0x12 data 0xBEEF with a controller model acking 4 cycles after the req rise -> req held with addr 0x12 / data 0xBEEF until ack; rspValid rises at ack edge; rspErr=0; rspRdData=0.
- Read addr 0x34, model returns 0xA5A5 with ack -> rspRdData=0xA5A5, rspErr=0; cpuMemRd=1 stable throughout REQ.
- Back-to-back read/write/read with rspReady tied high -> cpuMemReq low ≥2 cycles between requests; each access acked once; responses in order.
- No ack with TIMEOUT=16 -> rspValid=1, rspErr=1, rspRdData=0 exactly 16 cycles after req rise; req low. An ack injected 3 cycles later -> staleAck single pulse, no state change.
- rspReady held low 10 cycles -> rspValid/rspRdData stable, cmdReady=0, new cmdValid not accepted; accepted 2 cycles after rspReady.
- resetCore asserted 2 cycles into REQ -> all outputs at reset values immediately; cmdReady=1 after release; ack pulse after release -> staleAck=1.
